// File: rtl/lsu_mem_port.sv
// Load/store port between the M stage and the data-memory bus.
// One bus transaction per instruction; stalls the pipeline until ack or timeout.
module lsu_mem_port #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic        stall_m,
  output logic [31:0] read_data_m,
  output logic        misaligned_m,
  output logic        bus_err_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [1:0]    lane_q;
  logic [2:0]    f3_q;
  logic [31:0]   rdata_q;
  logic          mis_q;
  logic          err_q;

  logic        req;
  logic [1:0]  sz;
  logic [1:0]  lane;
  logic        misal;
  logic        accept;
  logic        to_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt;

  assign req  = mem_read_m | mem_write_m;
  assign sz   = funct3_m[1:0];
  assign lane = alu_result_m[1:0];

  assign misal = (sz == 2'b01 && lane[0]) ||
                 (sz[1] && lane != 2'b00);

  assign accept = (state_q == IDLE) && req && !misal;

  assign to_hit = (ACK_TIMEOUT > 0) &&
                  (cnt_q == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = write_data_m;
    unique case (1'b1)
      (sz == 2'b00): begin
        be_new    = 4'b0001 << lane;
        wdata_new = {4{write_data_m[7:0]}};
      end
      (sz == 2'b01): begin
        be_new    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{write_data_m[15:0]}};
      end
      sz[1]: begin
        be_new    = 4'b1111;
        wdata_new = write_data_m;
      end
    endcase
  end

  assign byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
  assign half_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    fmt = bus_rdata;
    case (f3_q)
      3'b000:  fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  fmt = {24'd0, byte_sel};
      3'b101:  fmt = {16'd0, half_sel};
      default: fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (bus_ack || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req = (state_q == BUSY);
    stall_m = accept || (state_q == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mis_q <= (state_q == IDLE) && req && misal;
      err_q <= (state_q == BUSY) && !bus_ack && to_hit;
      if (state_q == BUSY) cnt_q <= cnt_q + CW'(1);
      else                 cnt_q <= '0;
      if (accept) begin
        we_q    <= mem_write_m;
        addr_q  <= {alu_result_m[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        lane_q  <= lane;
        f3_q    <= funct3_m;
      end
      if ((state_q == IDLE) && req && misal) begin
        rdata_q <= '0;
      end else if (state_q == BUSY) begin
        if (bus_ack) begin
          if (!we_q) rdata_q <= fmt;
        end else if (to_hit) begin
          rdata_q <= '0;
        end
      end
    end
  end

  assign read_data_m  = rdata_q;
  assign misaligned_m = mis_q;
  assign bus_err_m    = err_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed table, reset corner case,
// then random traffic against a byte-level reference model.
module tb_lsu_mem_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [2:0]  funct3_m = '0;
  logic [31:0] alu_result_m = '0;
  logic [31:0] write_data_m = '0;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        misaligned_m;
  logic        bus_err_m;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  lsu_mem_port #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m),
    .stall_m(stall_m), .read_data_m(read_data_m),
    .misaligned_m(misaligned_m), .bus_err_m(bus_err_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    int          e_stall;
    int          e_req;
    int          e_mis;
    int          e_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request and play the bus side; request is held
  // while stalled and through the release cycle, as the pipeline would.
  task automatic run(
    input  logic        we, input logic [2:0] f3,
    input  logic [31:0] addr, input logic [31:0] wd,
    input  logic [31:0] rdata, input int waits,
    output int stalls, output int reqs, output int mis,
    output int err, output logic [31:0] rd,
    output logic [31:0] b_addr, output logic [3:0] b_be,
    output logic b_we, output logic [31:0] b_wdata,
    output bit stable);
    bit done;
    int post;
    int c;
    stalls = 0; reqs = 0; mis = 0; err = 0; rd = '0;
    b_addr = '0; b_be = '0; b_we = 1'b0; b_wdata = '0;
    stable = 1'b1; done = 1'b0; post = 0;
    @(negedge clk);
    mem_write_m  = we;
    mem_read_m   = !we;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    for (c = 0; c < 60 && post < 3; c++) begin
      #1;
      if (stall_m) stalls++;
      if (misaligned_m) mis++;
      if (bus_err_m) err++;
      if (bus_req) begin
        if (reqs == 0) begin
          b_addr = bus_addr; b_be = bus_be;
          b_we = bus_we; b_wdata = bus_wdata;
        end else if (b_addr !== bus_addr || b_be !== bus_be ||
                     b_we !== bus_we || b_wdata !== bus_wdata) begin
          stable = 1'b0;
        end
        bus_ack   = (reqs == waits);
        bus_rdata = rdata;
        reqs++;
      end else begin
        bus_ack = 1'b0;
      end
      if (done) begin
        post++;
        if (post == 1 && reqs == 0) rd = read_data_m;
      end else if (!stall_m) begin
        done = 1'b1;
        if (reqs > 0) rd = read_data_m;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      if (done) begin
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
      end
    end
    chk("cycle_budget", 32'(done), 32'd1);
  endtask

  task automatic check_all(input string tag, input logic [31:0] erd,
                           input int est, input int ereq,
                           input int emis, input int eerr,
                           input logic [31:0] ea, input logic [3:0] ebe,
                           input logic ewe, input logic [31:0] ewd,
                           input int st, input int rq, input int mi,
                           input int er, input logic [31:0] rd,
                           input logic [31:0] ba, input logic [3:0] bb,
                           input logic bw, input logic [31:0] bd,
                           input bit stable);
    chk({tag, ".stall"}, 32'(st), 32'(est));
    chk({tag, ".req"}, 32'(rq), 32'(ereq));
    chk({tag, ".mis"}, 32'(mi), 32'(emis));
    chk({tag, ".err"}, 32'(er), 32'(eerr));
    chk({tag, ".rd"}, rd, erd);
    if (ereq > 0) begin
      chk({tag, ".addr"}, ba, ea);
      chk({tag, ".be"}, 32'(bb), 32'(ebe));
      chk({tag, ".we"}, 32'(bw), 32'(ewe));
      if (ewe) chk({tag, ".wdata"}, bd, ewd);
      chk({tag, ".stable"}, 32'(stable), 32'd1);
    end
  endtask

  function automatic vec_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr,
                                 input logic [31:0] wd,
                                 input logic [31:0] rdata,
                                 input int waits,
                                 input logic [31:0] prev);
    vec_t v;
    int nb;
    int off;
    logic [31:0] mask;
    logic [31:0] val;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.waits = waits;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    v.e_addr  = addr - 32'(off);
    v.e_be    = 4'(((1 << nb) - 1) << off);
    v.e_wdata = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    v.e_mis = 0; v.e_err = 0;
    if (off % nb != 0) begin
      v.e_mis = 1; v.e_req = 0; v.e_stall = 0; v.e_rd = '0;
    end else if (waits >= TO) begin
      v.e_err = 1; v.e_req = TO; v.e_stall = TO + 1; v.e_rd = '0;
    end else begin
      v.e_req = waits + 1; v.e_stall = waits + 2;
      if (we) begin
        v.e_rd = prev;
      end else begin
        mask = (nb == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * nb)) - 1;
        val  = (rdata >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
        v.e_rd = val;
      end
    end
    return v;
  endfunction

  initial begin
    int st, rq, mi, er;
    logic [31:0] rd, ba, bd, prev;
    logic [3:0] bb;
    logic bw;
    bit stable;
    vec_t v;

    //        we  f3     addr          wd            rdata         w
    //        e_addr        be       e_wdata       e_rd          st rq mi er
    tbl[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2, 1, 0, 0};
    tbl[1] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0,
               32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 2, 1, 0, 0};
    tbl[2] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 0,
               32'h100, 4'b1000, 32'h0, 32'h00000080, 2, 1, 0, 0};
    tbl[3] = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3,
               32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080, 5, 4, 0, 0};
    tbl[4] = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0,
               32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0};
    tbl[5] = '{1'b0, 3'b001, 32'h106, 32'h0, 32'h80011234, 0,
               32'h104, 4'b1100, 32'h0, 32'hFFFF8001, 2, 1, 0, 0};
    tbl[6] = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 99,
               32'h300, 4'b1111, 32'h0, 32'h0, 5, 4, 0, 1};
    tbl[7] = '{1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1,
               32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0, 3, 2, 0, 0};
    tbl[8] = '{1'b0, 3'b100, 32'h102, 32'h0, 32'h00AB0000, 0,
               32'h100, 4'b0100, 32'h0, 32'h000000AB, 2, 1, 0, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.stall", 32'(stall_m), 32'd0);
    chk("rst.req", 32'(bus_req), 32'd0);
    chk("rst.rd", read_data_m, 32'd0);
    chk("rst.bus", {bus_addr[27:0], bus_be}, 32'd0);
    chk("rst.flags", {29'd0, bus_we, misaligned_m, bus_err_m}, 32'd0);

    foreach (tbl[i]) begin
      run(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
          tbl[i].rdata, tbl[i].waits,
          st, rq, mi, er, rd, ba, bb, bw, bd, stable);
      check_all($sformatf("tbl%0d", i), tbl[i].e_rd, tbl[i].e_stall,
                tbl[i].e_req, tbl[i].e_mis, tbl[i].e_err,
                tbl[i].e_addr, tbl[i].e_be, tbl[i].we, tbl[i].e_wdata,
                st, rq, mi, er, rd, ba, bb, bw, bd, stable);
    end

    // Reset during the 2nd BUSY cycle, then a late ack.
    @(negedge clk);
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h400;
    @(negedge clk);
    #1 chk("rstbusy.req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_read_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstbusy.req", 32'(bus_req), 32'd0);
    chk("rstbusy.stall", 32'(stall_m), 32'd0);
    chk("rstbusy.rd", read_data_m, 32'd0);
    chk("rstbusy.addr", bus_addr, 32'd0);
    chk("rstbusy.be_we", {27'd0, bus_we, bus_be}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("lateack.req", 32'(bus_req), 32'd0);
    chk("lateack.rd", read_data_m, 32'd0);
    chk("lateack.flags", {30'd0, misaligned_m, bus_err_m}, 32'd0);

    prev = read_data_m;
    for (int i = 0; i < 40; i++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd4;
        else if (f3 == 3'd4) f3 = 3'd5;
      end
      addr = $urandom;
      v = model(we, f3, addr, $urandom, $urandom,
                $urandom_range(0, 5), prev);
      run(v.we, v.f3, v.addr, v.wd, v.rdata, v.waits,
          st, rq, mi, er, rd, ba, bb, bw, bd, stable);
      check_all($sformatf("rnd%0d", i), v.e_rd, v.e_stall, v.e_req,
                v.e_mis, v.e_err, v.e_addr, v.e_be, v.we, v.e_wdata,
                st, rq, mi, er, rd, ba, bb, bw, bd, stable);
      prev = v.e_rd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
